ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
- Instruction prefetch queue; the producer side of the instruction-register load path.
- Fetches instruction words from memory at a sequential 18-bit PC and buffers them.
- Presents the head word on a 36-bit dbus with a valid flag; the IR latch consumes it with a one-cycle load pulse.
- Sits between the memory request interface and the IR/AC latch; flushed on every control transfer (start).

Parameters:
- DEPTH, 2, queue entries (power of two, 2..8).
- VAW, 18, virtual address width.
- WORDW, 36, instruction word width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  flush queue; load PC from start_addr; begin fetching.
- start_addr  in  VAW  new PC.
- halt  in  1  stop issuing new requests (level).
- mem_req  out  1  memory read request.
- mem_addr  out  VAW  read address, stable while mem_req=1.
- mem_ack  in  1  read complete; valid only while mem_req=1.
- mem_data  in  WORDW  read data, qualified by mem_ack.
- mem_nxm  in  1  non-existent memory, qualified by mem_ack.
- dbus  out  WORDW  head instruction word; 0 when empty.
- ipc  out  VAW  address of head word; 0 when empty.
- ivalid  out  1  head entry valid.
- ifault  out  1  head entry is a fault marker (dbus=0).
- ir_load  in  1  consumer takes head this cycle; ignored when ivalid=0.

Behaviour:
- Reset: state IDLE, pc=0, queue empty. All outputs 0: mem_req, mem_addr, dbus, ipc, ivalid, ifault.
- rst mid-request drops mem_req on the next edge. Any later mem_ack is ignored because req=0.
- Handshake:
  - mem_req and mem_addr stay asserted and stable until a cycle with mem_ack=1.
  - Ack is sampled on that edge. mem_req may deassert or re-issue on the following cycle.
  - At most one request is outstanding. No back-to-back gap is required.
- States:
  - IDLE: no request. Go to FETCH when count<DEPTH and halt=0 and a prior start has occurred.
  - FETCH: mem_req=1, mem_addr=pc.
    - On ack without nxm: push {mem_data, pc, fault=0}; pc<=pc+1.
    - Next state is FETCH if count-after-push<DEPTH and halt=0, else IDLE.
    - On ack with nxm: push {0, pc, fault=1}; go to STOP.
  - DISCARD: abandoned request still pending, mem_req=1 at the old address. On ack, drop the data and go to FETCH at the new pc.
  - STOP: no requests until start.
- start, from any state:
  - Queue cleared on the same edge; pc<=start_addr; ivalid=0 next cycle.
  - If a request is pending without ack this cycle: go to DISCARD.
  - If ack arrives in the same cycle as start: the data is dropped; go to FETCH.
  - start wins over a simultaneous ir_load and push.
- Queue latency: ack edge to ivalid=1 is one cycle (registered head).
- Simultaneous push and pop: count unchanged, order preserved.
- Pop on empty: ignored.
- A request is only started when count<DEPTH, so a push never overflows.
- PC arithmetic: modulo 2^VAW; 777777 (octal) wraps to 000000. No carry into other state.
- halt: an in-flight request completes and pushes, then IDLE. Deasserting halt resumes at pc. Queued entries remain consumable.

Decomposition:
- Package ifetch_pkg: VAW/WORDW constants; state encoding (IDLE, FETCH, DISCARD, STOP); entry type {word[WORDW], addr[VAW], fault}.
- Sub-module ifetch_fifo: DEPTH-entry synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: head entry, count, empty, full.
  - flush has priority over push/pop.

Test Plan:
- Sequential fetch: rst, start at 001000; mem acks every cycle with data=addr; ir_load tied 1 -> dbus/ipc sequence 001000, 001001, 001002...; first ivalid one cycle after first ack; no gaps.
- Backpressure: ir_load=0, DEPTH=2 -> exactly 2 requests (001000, 001001), then mem_req=0, ivalid=1. One ir_load pulse -> one new request at 001002.
- Flush mid-request: request at 001003 unacked; start to 002000; ack 3 cycles later with data 0o123 -> 0o123 never appears on dbus; next mem_addr=002000; ivalid=0 until its ack+1.
- NXM: ack with mem_nxm=1 at 001002 -> head entry ipc=001002, ifault=1, dbus=0; mem_req stays 0 until the next start.
- Wrap: start at 777776 -> mem_addr sequence 777776, 777777, 000000.
- Corner cases:
  - count=1 with simultaneous ack and ir_load -> count stays 1 and order is correct.
  - rst asserted while mem_req=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared widths, FSM encoding and queue entry layout for the instruction prefetch queue.
// No logic of its own; constants and types only.
// Not applicable: no handshake lives here.
package ifetch_pkg;

  localparam int VAW   = 18;
  localparam int WORDW = 36;

  // Fetch sequencer states
  localparam logic [1:0] ST_IDLE    = 2'd0;  // not requesting; waiting for room, halt release or start
  localparam logic [1:0] ST_FETCH   = 2'd1;  // request outstanding at pc
  localparam logic [1:0] ST_DISCARD = 2'd2;  // abandoned request still pending; its data is dropped
  localparam logic [1:0] ST_STOP    = 2'd3;  // non-existent memory hit; parked until start

  // One buffered instruction: word, the address it came from, and a fault marker
  typedef struct packed {
    logic [WORDW-1:0] word;
    logic [VAW-1:0]   addr;
    logic             fault;
  } entry_t;

  // Sequential PC advance, modulo 2^VAW
  function automatic logic [VAW-1:0] pc_next(input logic [VAW-1:0] pc);
    return pc + VAW'(1);
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Bundles the start/halt control, memory read handshake and IR-side head bus.
// Pure wiring; no latency.
// mem_req holds until mem_ack; the IR side pops with a one-cycle ir_load pulse.
interface ifetch_queue_if;
  import ifetch_pkg::*;

  logic             start;
  logic [VAW-1:0]   start_addr;
  logic             halt;

  logic             mem_req;
  logic [VAW-1:0]   mem_addr;
  logic             mem_ack;
  logic [WORDW-1:0] mem_data;
  logic             mem_nxm;

  logic [WORDW-1:0] dbus;
  logic [VAW-1:0]   ipc;
  logic             ivalid;
  logic             ifault;
  logic             ir_load;

  // The prefetch queue itself
  modport master (
    input  start, start_addr, halt,
    output mem_req, mem_addr,
    input  mem_ack, mem_data, mem_nxm,
    output dbus, ipc, ivalid, ifault,
    input  ir_load
  );

  // Sequencer, memory and IR latch side
  modport slave (
    output start, start_addr, halt,
    input  mem_req, mem_addr,
    output mem_ack, mem_data, mem_nxm,
    input  dbus, ipc, ivalid, ifault,
    output ir_load
  );

endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched instruction entries with registered storage.
// Write on one edge, visible at head the following cycle.
// Push while full is dropped, pop while empty is ignored; flush beats both.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_C);
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (!do_push && do_pop) cnt <= cnt - CW'(1);
    end
  end

  // Entry storage; contents are only observed through a non-empty head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: sequential fetch at pc into a small FIFO feeding the IR latch.
// Ack edge to ivalid is one cycle; back-to-back requests issue with no gap while room remains.
// Stops requesting when the queue would fill or halt is high; resumes as soon as room frees.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  ifetch_queue_if.master  io
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [1:0]      state;
  logic [VAW-1:0]  pc;
  logic [VAW-1:0]  disc_addr;   // address of an abandoned request still on the bus
  logic            armed;       // a start has been seen since reset

  logic            req_on;
  logic [VAW-1:0]  addr_out;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head;
  logic [CW-1:0]   count;
  logic [CW-1:0]   cnt_after;
  logic            empty;
  logic            full;

  // Request outputs come straight from state so they are stable until the ack edge
  always_comb begin
    req_on   = 1'b0;
    addr_out = '0;
    case (state)
      ST_FETCH: begin
        req_on   = 1'b1;
        addr_out = pc;
      end
      ST_DISCARD: begin
        req_on   = 1'b1;
        addr_out = disc_addr;
      end
      default: ;
    endcase
  end

  // start flushes the queue, so it suppresses both the push of a same-cycle ack and any pop
  always_comb begin
    push       = (state == ST_FETCH) && io.mem_ack && !io.start;
    pop        = io.ir_load && !empty && !io.start;
    push_entry = io.mem_nxm ? '{word: '0, addr: pc, fault: 1'b1}
                            : '{word: io.mem_data, addr: pc, fault: 1'b0};
    cnt_after  = count;
    if (push && !pop)      cnt_after = count + CW'(1);
    else if (!push && pop) cnt_after = count - CW'(1);
  end

  // Fetch sequencer: issue, retire, discard and stop handling
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      disc_addr <= '0;
      armed     <= 1'b0;
    end else if (io.start) begin
      pc        <= io.start_addr;
      armed     <= 1'b1;
      disc_addr <= addr_out;
      if (req_on && !io.mem_ack) state <= ST_DISCARD;
      else                       state <= io.halt ? ST_IDLE : ST_FETCH;
    end else begin
      case (state)
        ST_IDLE: begin
          if (armed && !io.halt && !full) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (io.mem_ack) begin
            if (io.mem_nxm) begin
              state <= ST_STOP;
            end else begin
              pc    <= pc_next(pc);
              state <= (cnt_after < DEPTH_C && !io.halt) ? ST_FETCH : ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (io.mem_ack) state <= io.halt ? ST_IDLE : ST_FETCH;
        end
        ST_STOP: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (io.start),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign io.mem_req  = req_on;
  assign io.mem_addr = addr_out;
  assign io.ivalid   = !empty;
  assign io.dbus     = empty ? '0 : head.word;
  assign io.ipc      = empty ? '0 : head.addr;
  assign io.ifault   = !empty && head.fault;

endmodule
